// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared state encoding and default sizes for the load/store access stage
package mem_access_pkg;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 16;
   localparam int DEF_DEPTH  = 1024;
   localparam int DEF_CNT_W  = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that sticks at its all-ones value
module sat_counter
   import mem_access_pkg::*;
#(
   parameter int W = DEF_CNT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single-outstanding load/store stage driving a synchronous-read data memory
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_store,
   input  logic [ADDR_W-1:0] req_base,
   input  logic [ADDR_W-1:0] req_offset,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_fault,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [CNT_W-1:0]  load_cnt,
   output logic [CNT_W-1:0]  store_cnt,
   output logic [CNT_W-1:0]  fault_cnt
);

   // One extra bit so a DEPTH equal to 2^ADDR_W still compares correctly.
   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

   state_t            state;
   logic              store_q;
   logic              fault_q;
   logic [ADDR_W-1:0] ea;
   logic              accept;
   logic              rsp_hs;

   assign ea        = req_base + req_offset;
   assign req_ready = (state == IDLE) && !rst;
   assign accept    = req_valid && req_ready;
   assign rsp_hs    = rsp_valid && rsp_ready;

   // Gated by rst so a reset landing on the ISSUE cycle cannot corrupt memory.
   assign mem_we = (state == ISSUE) && store_q && !fault_q && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         store_q   <= 1'b0;
         fault_q   <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_fault <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  store_q   <= req_store;
                  fault_q   <= ({1'b0, ea} >= DEPTH_X);
                  mem_addr  <= ea;
                  mem_wdata <= req_wdata;
                  rsp_data  <= '0;
                  rsp_fault <= 1'b0;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               if (fault_q || store_q) begin
                  rsp_fault <= fault_q;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               rsp_data  <= mem_rdata;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   sat_counter #(.W(CNT_W)) u_load_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (rsp_hs && !store_q && !fault_q),
      .count (load_cnt)
   );

   sat_counter #(.W(CNT_W)) u_store_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (rsp_hs && store_q && !fault_q),
      .count (store_cnt)
   );

   sat_counter #(.W(CNT_W)) u_fault_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (rsp_hs && fault_q),
      .count (fault_cnt)
   );

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed bench for mem_access_unit with a behavioural data memory
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst, req_valid, req_store, rsp_ready;
   logic [15:0] req_base, req_offset, req_wdata, mem_rdata;
   logic        req_ready, rsp_valid, rsp_fault, mem_we;
   logic [15:0] rsp_data, mem_addr, mem_wdata, load_cnt, store_cnt, fault_cnt;
   logic [15:0] mem [0:1023];
   logic [15:0] we_addr = '0;
   int          checks = 0, failures = 0, we_cnt = 0, hs_cnt = 0;

   always #5 clk = ~clk;

   mem_access_unit dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_store  (req_store),
      .req_base   (req_base),
      .req_offset (req_offset),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_fault  (rsp_fault),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .load_cnt   (load_cnt),
      .store_cnt  (store_cnt),
      .fault_cnt  (fault_cnt)
   );

   // Read-first synchronous memory plus write and handshake monitors.
   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr[9:0]] <= mem_wdata;
         we_cnt  <= we_cnt + 1;
         we_addr <= mem_addr;
      end
      mem_rdata <= mem[mem_addr[9:0]];
      if (rsp_valid && rsp_ready) hs_cnt <= hs_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic do_req(input logic st, input logic [15:0] b, input logic [15:0] o,
                         input logic [15:0] d, output int lat, output logic [15:0] data,
                         output logic flt, output int waited);
      req_store = st; req_base = b; req_offset = o; req_wdata = d; req_valid = 1'b1;
      waited = 0;
      while (!req_ready && waited < 50) begin @(posedge clk); #1; waited++; end
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
      data = rsp_data;
      flt  = rsp_fault;
      if (rsp_ready) begin @(posedge clk); #1; end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat, w, we0, hs0;
      logic [15:0] d;
      logic        f, ok_v, ok_d, ok_r;

      for (int i = 0; i < 1024; i++) mem[i] = '0;
      mem[32]    = 16'h1001;
      mem_rdata  = '0;
      rst        = 1'b1;
      req_valid  = 1'b0; req_store = 1'b0;
      req_base   = '0; req_offset = '0; req_wdata = '0;
      rsp_ready  = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rsp_fault", rsp_fault, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_cnts", {load_cnt, store_cnt} | {16'h0, fault_cnt}, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("post_rst_req_ready", req_ready, 1);

      // Basic store then load back.
      we0 = we_cnt;
      do_req(1'b1, 16'h0010, 16'h0005, 16'h1DFE, lat, d, f, w);
      check("st_lat", lat, 2);
      check("st_fault", f, 0);
      check("st_data", d, 0);
      check("st_we_pulses", we_cnt - we0, 1);
      check("st_we_addr", we_addr, 16'h0015);
      check("st_mem", mem[21], 16'h1DFE);
      check("st_cnt", store_cnt, 1);

      do_req(1'b0, 16'h0010, 16'h0005, 16'h0000, lat, d, f, w);
      check("ld_lat", lat, 3);
      check("ld_data", d, 16'h1DFE);
      check("ld_fault", f, 0);
      check("ld_cnt", load_cnt, 1);

      // Last legal word, then one past the end.
      we0 = we_cnt;
      do_req(1'b1, 16'h03FF, 16'h0000, 16'h5A5A, lat, d, f, w);
      check("edge_st_lat", lat, 2);
      check("edge_st_fault", f, 0);
      check("edge_st_we", we_cnt - we0, 1);
      check("edge_st_addr", we_addr, 16'h03FF);
      we0 = we_cnt;
      do_req(1'b1, 16'h03FF, 16'h0001, 16'hDEAD, lat, d, f, w);
      check("flt_lat", lat, 2);
      check("flt_fault", f, 1);
      check("flt_data", d, 0);
      check("flt_no_we", we_cnt - we0, 0);
      check("flt_cnt", fault_cnt, 1);
      check("flt_store_cnt", store_cnt, 2);

      // Address wrap-around lands on word 1.
      do_req(1'b1, 16'hFFFF, 16'h0002, 16'hA001, lat, d, f, w);
      check("wrap_st_fault", f, 0);
      check("wrap_st_addr", we_addr, 16'h0001);
      do_req(1'b0, 16'h0000, 16'h0001, 16'h0000, lat, d, f, w);
      check("wrap_ld_data", d, 16'hA001);
      check("wrap_cnts", {load_cnt, store_cnt}, {16'd2, 16'd3});

      // Response back-pressure with a new request already waiting.
      rsp_ready = 1'b0;
      do_req(1'b0, 16'h03FF, 16'h0000, 16'h0000, lat, d, f, w);
      check("bp_lat", lat, 3);
      check("bp_data", d, 16'h5A5A);
      req_store = 1'b1; req_base = 16'h0030; req_offset = '0; req_wdata = 16'h7777;
      req_valid = 1'b1;
      ok_v = 1'b1; ok_d = 1'b1; ok_r = 1'b1;
      for (int i = 0; i < 5; i++) begin
         ok_v &= rsp_valid;
         ok_d &= (rsp_data == 16'h5A5A);
         ok_r &= !req_ready;
         @(posedge clk); #1;
      end
      check("bp_valid_held", ok_v, 1);
      check("bp_data_held", ok_d, 1);
      check("bp_ready_low", ok_r, 1);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_ready_after_hs", req_ready, 1);
      check("bp_load_cnt", load_cnt, 3);
      do_req(1'b1, 16'h0030, 16'h0000, 16'h7777, lat, d, f, w);
      check("bp_next_wait", w, 0);
      check("bp_next_lat", lat, 2);
      check("bp_next_mem", mem[48], 16'h7777);

      // Reset while a store sits in ISSUE.
      hs0 = hs_cnt;
      we0 = we_cnt;
      req_store = 1'b1; req_base = 16'h0020; req_offset = '0; req_wdata = 16'hBEEF;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("abort_in_issue", mem_we, 1);
      rst = 1'b1;
      #1;
      check("abort_we_gated", mem_we, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_no_write", we_cnt - we0, 0);
      check("abort_load_cnt", load_cnt, 0);
      check("abort_store_cnt", store_cnt, 0);
      check("abort_fault_cnt", fault_cnt, 0);
      repeat (4) @(posedge clk);
      #1;
      check("abort_no_rsp", hs_cnt - hs0, 0);
      do_req(1'b0, 16'h0020, 16'h0000, 16'h0000, lat, d, f, w);
      check("abort_ld_data", d, 16'h1001);
      check("abort_ld_cnt", load_cnt, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
